// File: rtl/video_ula_if.sv
// CPU write-bus bundle for video_ula: bus-cycle enable, chip select, register select and data.
interface video_ula_if;
  logic       cpu_en;
  logic       nCS;
  logic       A0;
  logic [7:0] data_bus;

  modport master (output cpu_en, nCS, A0, data_bus);
  modport slave  (input  cpu_en, nCS, A0, data_bus);
endinterface

// File: rtl/video_ula.sv
// video_ula: CRTC character-clock generator, display-byte serialiser, 16-entry palette and cursor overlay.
// Optional teletext colour path is enabled by defining VIDEO_ULA_TELETEXT_EN.
module video_ula (
  input  logic       pixel_clk,
  input  logic       nRESET,
  video_ula_if.slave bus,
  input  logic [7:0] vram_data,
  input  logic       display_en,
  input  logic       cursor,
  input  logic [2:0] ttx_rgb,
  output logic       crtc_clk,
  output logic       R,
  output logic       G,
  output logic       B
);
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic [7:0] ctrl_r;
  logic [7:0] ctrl_nxt_s;
  logic [3:0] pal_r [16];
  logic [7:0] sr_r;
  logic       blank_r;
  logic [3:0] cur_r;
  logic [2:0] rgb_r;
  logic       crtc_clk_r;
  logic       wr_s;
  logic       pal_wr_s;
  logic       crtc_nxt_s;
  logic       tick_s;
  logic [3:0] idx_s;
  logic [3:0] entry_s;
  logic [2:0] base_s;
  logic [2:0] vis_s;
  logic [2:0] pix_s;

  // Entries store the inverted colour; bit 3 marks a flashing entry that re-inverts while flash is on.
  function automatic logic [2:0] phys_colour(input logic [3:0] entry, input logic flash);
    phys_colour = entry[2:0] ^ 3'b111 ^ ((entry[3] & flash) ? 3'b111 : 3'b000);
  endfunction

  // CPU write decode and the divider/control values that the next edge will hold.
  always_comb begin
    wr_s       = bus.cpu_en & ~bus.nCS;
    pal_wr_s   = wr_s & bus.A0;
    ctrl_nxt_s = ctrl_r;
    if (wr_s && !bus.A0) begin
      ctrl_nxt_s = bus.data_bus;
    end else begin
      ctrl_nxt_s = ctrl_r;
    end
    cnt_nxt_s  = cnt_r + 4'd1;
    crtc_nxt_s = 1'b0;
    if (ctrl_nxt_s[4]) begin
      crtc_nxt_s = (cnt_nxt_s[2:0] == 3'd7);
    end else begin
      crtc_nxt_s = (cnt_nxt_s == 4'd15);
    end
  end

  // Pixel tick selected by the pixel-rate field of the control register.
  always_comb begin
    tick_s = 1'b0;
    case (ctrl_r[3:2])
      2'b00:   tick_s = (cnt_r[2:0] == 3'd7);
      2'b01:   tick_s = (cnt_r[1:0] == 2'd3);
      2'b10:   tick_s = cnt_r[0];
      2'b11:   tick_s = 1'b1;
      default: tick_s = 1'b0;
    endcase
  end

  assign idx_s   = {sr_r[7], sr_r[5], sr_r[3], sr_r[1]};
  assign entry_s = pal_r[idx_s];

`ifdef VIDEO_ULA_TELETEXT_EN
  assign base_s = ctrl_r[1] ? ttx_rgb : phys_colour(entry_s, ctrl_r[0]);
`else
  assign base_s = phys_colour(entry_s, ctrl_r[0]);
  logic unused_s;
  assign unused_s = ^{ttx_rgb, ctrl_r[1]};
`endif

  // Blanking forces black first; the cursor then inverts, so blanked cursor cells show white.
  assign vis_s = blank_r ? 3'b000 : base_s;
  assign pix_s = cur_r[3] ? (vis_s ^ 3'b111) : vis_s;

  // Divider, registered character-clock enable and CPU-written registers.
  always_ff @(posedge pixel_clk or negedge nRESET) begin
    if (!nRESET) begin
      cnt_r      <= 4'd0;
      crtc_clk_r <= 1'b0;
      ctrl_r     <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        pal_r[i] <= 4'h7;
      end
    end else begin
      cnt_r      <= cnt_nxt_s;
      crtc_clk_r <= crtc_nxt_s;
      ctrl_r     <= ctrl_nxt_s;
      if (pal_wr_s) begin
        pal_r[bus.data_bus[7:4]] <= bus.data_bus[3:0];
      end
    end
  end

  // Byte shifter, blank flag and cursor shifter; a load takes priority over a pixel tick.
  always_ff @(posedge pixel_clk or negedge nRESET) begin
    if (!nRESET) begin
      sr_r    <= 8'h00;
      blank_r <= 1'b0;
      cur_r   <= 4'h0;
    end else if (crtc_clk_r) begin
      sr_r    <= display_en ? vram_data : 8'h00;
      blank_r <= ~display_en;
      cur_r   <= cursor ? {ctrl_r[7:5], ctrl_r[5]} : {cur_r[2:0], 1'b0};
    end else if (tick_s) begin
      sr_r    <= {sr_r[6:0], 1'b1};
    end
  end

  // Output pixel register, computed from the state left by the previous edge.
  always_ff @(posedge pixel_clk or negedge nRESET) begin
    if (!nRESET) begin
      rgb_r <= 3'b000;
    end else begin
      rgb_r <= pix_s;
    end
  end

  assign crtc_clk = crtc_clk_r;
  assign R        = rgb_r[2];
  assign G        = rgb_r[1];
  assign B        = rgb_r[0];
endmodule

// File: tb/tb_video_ula.sv
// Self-checking bench for video_ula: directed scenarios plus randomized traffic against a behavioural model.
module tb_video_ula;
  logic       pixel_clk = 1'b0;
  logic       nRESET    = 1'b1;
  logic [7:0] vram_data = 8'h00;
  logic       display_en = 1'b0;
  logic       cursor    = 1'b0;
  logic [2:0] ttx_rgb   = 3'b000;
  logic       crtc_clk;
  logic       R, G, B;
  int         n_tests = 0;
  int         n_fail  = 0;

  video_ula_if bus ();

  video_ula dut (
    .pixel_clk  (pixel_clk),
    .nRESET     (nRESET),
    .bus        (bus),
    .vram_data  (vram_data),
    .display_en (display_en),
    .cursor     (cursor),
    .ttx_rgb    (ttx_rgb),
    .crtc_clk   (crtc_clk),
    .R          (R),
    .G          (G),
    .B          (B)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Behavioural reference: edge count modulo 16, periods as integers, colours as arithmetic.
  int         m_cnt;
  logic [7:0] m_ctrl;
  logic [3:0] m_pal [16];
  logic [7:0] m_sr;
  logic       m_blank;
  logic [3:0] m_cur;
  logic [2:0] m_rgb;

  function automatic bit ref_load();
    int period;
    period = m_ctrl[4] ? 8 : 16;
    return ((m_cnt + 1) % period) == 0;
  endfunction

  function automatic bit ref_tick();
    int period;
    period = 8 >> m_ctrl[3:2];
    return ((m_cnt + 1) % period) == 0;
  endfunction

  function automatic logic [2:0] ref_pixel();
    int idx;
    int c;
    logic [3:0] e;
    idx = 8 * int'(m_sr[7]) + 4 * int'(m_sr[5]) + 2 * int'(m_sr[3]) + int'(m_sr[1]);
    e   = m_pal[idx];
    if (e[3] && m_ctrl[0]) c = int'(e[2:0]);
    else c = 7 - int'(e[2:0]);
`ifdef VIDEO_ULA_TELETEXT_EN
    if (m_ctrl[1]) c = int'(ttx_rgb);
`endif
    if (m_blank) c = 0;
    if (m_cur[3]) c = 7 - c;
    return 3'(c);
  endfunction

  always @(posedge pixel_clk or negedge nRESET) begin
    if (!nRESET) begin
      m_cnt   <= 0;
      m_ctrl  <= 8'h00;
      m_sr    <= 8'h00;
      m_blank <= 1'b0;
      m_cur   <= 4'h0;
      m_rgb   <= 3'b000;
      for (int i = 0; i < 16; i++) m_pal[i] <= 4'h7;
    end else begin
      m_rgb <= ref_pixel();
      if (ref_load()) begin
        m_sr    <= display_en ? vram_data : 8'h00;
        m_blank <= !display_en;
        if (cursor) m_cur <= {m_ctrl[7:5], m_ctrl[5]};
        else m_cur <= 4'((int'(m_cur) * 2) % 16);
      end else if (ref_tick()) begin
        m_sr <= 8'((int'(m_sr) * 2 + 1) % 256);
      end
      if (bus.cpu_en && !bus.nCS) begin
        if (bus.A0) m_pal[bus.data_bus[7:4]] <= bus.data_bus[3:0];
        else m_ctrl <= bus.data_bus;
      end
      m_cnt <= (m_cnt + 1) % 16;
    end
  end

  task automatic cpu_write(input logic a0, input logic [7:0] d);
    @(negedge pixel_clk);
    bus.cpu_en = 1'b1; bus.nCS = 1'b0; bus.A0 = a0; bus.data_bus = d;
    @(negedge pixel_clk);
    bus.cpu_en = 1'b0; bus.nCS = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    bus.cpu_en = 1'b0; bus.nCS = 1'b1; bus.A0 = 1'b0; bus.data_bus = 8'h00;
    #2 nRESET = 1'b0;
    repeat (3) @(negedge pixel_clk);
    n_tests++;
    if ({R, G, B} !== 3'b000 || crtc_clk !== 1'b0) begin
      n_fail++; $display("FAIL reset_state rgb=%b crtc_clk=%b expected 000/0", {R, G, B}, crtc_clk);
    end
    nRESET = 1'b1;
    pulses = 0;
    display_en = 1'b1; vram_data = 8'h5A;
    for (int i = 0; i < 64; i++) begin
      @(negedge pixel_clk);
      if (crtc_clk === 1'b1) pulses++;
      n_tests++;
      if ({R, G, B} !== 3'b000 || crtc_clk !== ref_load()) begin
        n_fail++; $display("FAIL idle cyc=%0d rgb=%b crtc=%b expected 000/%b", i, {R, G, B}, crtc_clk, ref_load());
      end
    end
    n_tests++;
    if (pulses !== 4) begin
      n_fail++; $display("FAIL idle_pulses got %0d expected 4", pulses);
    end
  endtask

  task automatic test_palette_pixels();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00; bytes[1] = 8'hAA; bytes[2] = 8'h3C;
    cpu_write(1'b0, 8'h1C);
    cpu_write(1'b1, 8'h07);
    cpu_write(1'b1, 8'hF0);
    display_en = 1'b1; cursor = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vram_data = bytes[k];
      if (k == 1) begin
        cpu_write(1'b1, 8'h06);
        cpu_write(1'b1, 8'hF7);
      end
      for (int i = 0; i < 24; i++) begin
        @(negedge pixel_clk);
        n_tests++;
        if ({R, G, B} !== m_rgb || crtc_clk !== ref_load()) begin
          n_fail++; $display("FAIL pixels byte=%h cyc=%0d rgb=%b crtc=%b expected %b/%b", bytes[k], i, {R, G, B}, crtc_clk, m_rgb, ref_load());
        end
      end
    end
  endtask

  task automatic test_flash();
    int white;
    cpu_write(1'b1, 8'h08);
    vram_data = 8'h00; display_en = 1'b1; cursor = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cpu_write(1'b0, (f == 0) ? 8'h1C : 8'h1D);
      repeat (16) @(negedge pixel_clk);
      white = 0;
      for (int i = 0; i < 32; i++) begin
        @(negedge pixel_clk);
        if ({R, G, B} === 3'b111) white++;
        n_tests++;
        if ({R, G, B} !== m_rgb) begin
          n_fail++; $display("FAIL flash%0d cyc=%0d rgb=%b expected %b", f, i, {R, G, B}, m_rgb);
        end
      end
      n_tests++;
      if (white !== ((f == 0) ? 8 : 0)) begin
        n_fail++; $display("FAIL flash%0d_white_count got %0d expected %0d", f, white, (f == 0) ? 8 : 0);
      end
    end
  endtask

  task automatic test_blank_cursor();
    int white;
    cpu_write(1'b1, 8'h00);
    cpu_write(1'b0, 8'h10);
    display_en = 1'b0; cursor = 1'b0; vram_data = 8'hFF;
    repeat (10) @(negedge pixel_clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge pixel_clk);
      n_tests++;
      if ({R, G, B} !== 3'b000) begin
        n_fail++; $display("FAIL blank cyc=%0d rgb=%b expected 000", i, {R, G, B});
      end
    end
    cpu_write(1'b0, 8'h90);
    repeat (12) @(negedge pixel_clk);
    white = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge pixel_clk);
      if ({R, G, B} === 3'b111) white++;
      n_tests++;
      if ({R, G, B} !== m_rgb) begin
        n_fail++; $display("FAIL cursor cyc=%0d rgb=%b expected %b", i, {R, G, B}, m_rgb);
      end
      cursor = (i < 8);
    end
    n_tests++;
    if (white !== 8) begin
      n_fail++; $display("FAIL cursor_white_count got %0d expected 8", white);
    end
    cursor = 1'b0;
  endtask

  task automatic test_teletext();
    cpu_write(1'b0, 8'h12);
    ttx_rgb = 3'b101; display_en = 1'b1; vram_data = 8'h33; cursor = 1'b0;
    repeat (20) @(negedge pixel_clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge pixel_clk);
      n_tests++;
`ifdef VIDEO_ULA_TELETEXT_EN
      if ({R, G, B} !== 3'b101) begin
        n_fail++; $display("FAIL teletext cyc=%0d rgb=%b expected 101", i, {R, G, B});
      end
`else
      if ({R, G, B} !== m_rgb) begin
        n_fail++; $display("FAIL teletext_off cyc=%0d rgb=%b expected %b", i, {R, G, B}, m_rgb);
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge pixel_clk);
      n_tests++;
      if ({R, G, B} !== m_rgb || crtc_clk !== ref_load()) begin
        n_fail++; $display("FAIL random cyc=%0d rgb=%b crtc=%b expected %b/%b", i, {R, G, B}, crtc_clk, m_rgb, ref_load());
      end
      vram_data  = 8'($urandom);
      display_en = ($urandom_range(0, 7) != 0);
      cursor     = ($urandom_range(0, 15) == 0);
      ttx_rgb    = 3'($urandom);
      bus.cpu_en = ($urandom_range(0, 5) == 0);
      bus.nCS    = ($urandom_range(0, 3) == 0);
      bus.A0     = 1'($urandom);
      bus.data_bus = 8'($urandom);
      if (i == 700) begin
        #2 nRESET = 1'b0;
        #1;
        n_tests++;
        if ({R, G, B} !== 3'b000 || crtc_clk !== 1'b0) begin
          n_fail++; $display("FAIL mid_reset rgb=%b crtc=%b expected 000/0", {R, G, B}, crtc_clk);
        end
        #1 nRESET = 1'b1;
      end
    end
    bus.cpu_en = 1'b0; bus.nCS = 1'b1;
  endtask

  initial begin
    test_reset();
    test_palette_pixels();
    test_flash();
    test_blank_cursor();
    test_teletext();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
